// File: rtl/regfile_2r1w.sv
// Parametrised 2-read/1-write register file with per-register pending (scoreboard) bits.
// Per-register storage and per-port read logic are replicated via generate arrays.

module regfile_2r1w_entry #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             lk,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] q,
    output logic             pend_d
);
    logic pend_q;

    // A lock at the same edge as the write-back wins: a new producer is in flight.
    assign pend_d = lk ? 1'b1 : (we ? 1'b0 : pend_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q      <= '0;
            pend_q <= 1'b0;
        end else begin
            if (we) q <= wdata;
            pend_q <= pend_d;
        end
    end
endmodule

module regfile_2r1w_rport #(
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                ren,
    input  logic [ADDR_W-1:0]                   raddr,
    input  logic [(1<<ADDR_W)-1:0][WIDTH-1:0]   mem,
    input  logic [(1<<ADDR_W)-1:0]              pend_d,
    input  logic                                wr_ok,
    input  logic [ADDR_W-1:0]                   waddr,
    input  logic [WIDTH-1:0]                    wdata,
    output logic [WIDTH-1:0]                    rdata,
    output logic                                busy
);
    logic [WIDTH-1:0] src;

    always_comb begin
        src = mem[raddr];
        if (ZERO_REG != 0 && raddr == '0)
            src = '0;
        else if (BYPASS != 0 && wr_ok && waddr == raddr)
            src = wdata;
    end

    // busy reports the post-edge pending state, so it already reflects this edge's write/lock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
            busy  <= 1'b0;
        end else if (ren) begin
            rdata <= src;
            busy  <= pend_d[raddr];
        end
    end
endmodule

module regfile_2r1w #(
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              lock,
    input  logic [ADDR_W-1:0] lock_addr,
    input  logic              ren_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    output logic              busy_a,
    input  logic              ren_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    output logic              busy_b
);
    localparam int DEPTH = 1 << ADDR_W;

    logic                        wr_ok, lk_ok;
    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [DEPTH-1:0]            pend_d;

    // Register 0 swallows writes and locks entirely when it is hardwired to zero.
    assign wr_ok = write && !(ZERO_REG != 0 && waddr == '0);
    assign lk_ok = lock && !(ZERO_REG != 0 && lock_addr == '0);

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        regfile_2r1w_entry #(.WIDTH(WIDTH)) u_ent (
            .clk    (clk),
            .rst    (rst),
            .we     (wr_ok && waddr == ADDR_W'(i)),
            .lk     (lk_ok && lock_addr == ADDR_W'(i)),
            .wdata  (wdata),
            .q      (mem[i]),
            .pend_d (pend_d[i])
        );
    end

    logic [1:0]                   ren_v, busy_v;
    logic [1:0][ADDR_W-1:0]       raddr_v;
    logic [1:0][WIDTH-1:0]        rdata_v;

    assign ren_v   = {ren_b, ren_a};
    assign raddr_v = {raddr_b, raddr_a};

    for (genvar p = 0; p < 2; p++) begin : g_rp
        regfile_2r1w_rport #(
            .WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
        ) u_rp (
            .clk    (clk),
            .rst    (rst),
            .ren    (ren_v[p]),
            .raddr  (raddr_v[p]),
            .mem    (mem),
            .pend_d (pend_d),
            .wr_ok  (wr_ok),
            .waddr  (waddr),
            .wdata  (wdata),
            .rdata  (rdata_v[p]),
            .busy   (busy_v[p])
        );
    end

    assign rdata_a = rdata_v[0];
    assign rdata_b = rdata_v[1];
    assign busy_a  = busy_v[0];
    assign busy_b  = busy_v[1];
endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: three configurations driven in lockstep (8x4 bypass, 8x4 zero-reg
// no-bypass, 16x8 bypass), checked by directed scenarios and a random run against an array model.

module tb_regfile_2r1w;
    logic        clk, rst;
    logic        write, lock, ren_a, ren_b;
    logic [2:0]  waddr, lock_addr, raddr_a, raddr_b;
    logic [15:0] wdata;

    logic [7:0]  rda0, rdb0, rda1, rdb1;
    logic [15:0] rda2, rdb2;
    logic        ba0, bb0, ba1, bb1, ba2, bb2;

    logic [15:0] ara[3], arb[3];
    logic        aba[3], abb[3];

    int checks = 0;
    int failures = 0;

    // Reference model state, per configuration
    logic [15:0] mm[3][8];
    logic [7:0]  mp[3];
    logic [15:0] erda[3], erdb[3];
    logic        eba[3], ebb[3];
    const bit    zr[3] = '{1'b0, 1'b1, 1'b0};
    const bit    bp[3] = '{1'b1, 1'b0, 1'b1};

    regfile_2r1w #(.WIDTH(8), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1)) dut0 (
        .clk(clk), .rst(rst), .write(write), .waddr(waddr[1:0]), .wdata(wdata[7:0]),
        .lock(lock), .lock_addr(lock_addr[1:0]),
        .ren_a(ren_a), .raddr_a(raddr_a[1:0]), .rdata_a(rda0), .busy_a(ba0),
        .ren_b(ren_b), .raddr_b(raddr_b[1:0]), .rdata_b(rdb0), .busy_b(bb0));

    regfile_2r1w #(.WIDTH(8), .ADDR_W(2), .ZERO_REG(1), .BYPASS(0)) dut1 (
        .clk(clk), .rst(rst), .write(write), .waddr(waddr[1:0]), .wdata(wdata[7:0]),
        .lock(lock), .lock_addr(lock_addr[1:0]),
        .ren_a(ren_a), .raddr_a(raddr_a[1:0]), .rdata_a(rda1), .busy_a(ba1),
        .ren_b(ren_b), .raddr_b(raddr_b[1:0]), .rdata_b(rdb1), .busy_b(bb1));

    regfile_2r1w #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) dut2 (
        .clk(clk), .rst(rst), .write(write), .waddr(waddr), .wdata(wdata),
        .lock(lock), .lock_addr(lock_addr),
        .ren_a(ren_a), .raddr_a(raddr_a), .rdata_a(rda2), .busy_a(ba2),
        .ren_b(ren_b), .raddr_b(raddr_b), .rdata_b(rdb2), .busy_b(bb2));

    always_comb begin
        ara[0] = {8'h00, rda0}; arb[0] = {8'h00, rdb0}; aba[0] = ba0; abb[0] = bb0;
        ara[1] = {8'h00, rda1}; arb[1] = {8'h00, rdb1}; aba[1] = ba1; abb[1] = bb1;
        ara[2] = rda2;          arb[2] = rdb2;          aba[2] = ba2; abb[2] = bb2;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 8; r++) mm[c][r] = '0;
            mp[c] = '0; erda[c] = '0; erdb[c] = '0; eba[c] = 1'b0; ebb[c] = 1'b0;
        end
    endtask

    // One rising edge as seen by the rules: reads see the old array (or the bypassed write),
    // busy sees the pending set after this edge's write and lock.
    task automatic model_edge();
        logic [2:0]  am, wa, la, ra, rb;
        logic [15:0] dm, wd, sa, sb;
        logic        wv, lv;
        logic [7:0]  p;
        for (int c = 0; c < 3; c++) begin
            am = (c == 2) ? 3'd7 : 3'd3;
            dm = (c == 2) ? 16'hFFFF : 16'h00FF;
            wa = waddr & am; la = lock_addr & am; ra = raddr_a & am; rb = raddr_b & am;
            wd = wdata & dm;
            wv = write && !(zr[c] && wa == 0);
            lv = lock && !(zr[c] && la == 0);
            p = mp[c];
            if (wv) p[wa] = 1'b0;
            if (lv) p[la] = 1'b1;
            sa = (zr[c] && ra == 0) ? 16'h0 : (bp[c] && wv && wa == ra) ? wd : mm[c][ra];
            sb = (zr[c] && rb == 0) ? 16'h0 : (bp[c] && wv && wa == rb) ? wd : mm[c][rb];
            if (ren_a) begin erda[c] = sa; eba[c] = p[ra]; end
            if (ren_b) begin erdb[c] = sb; ebb[c] = p[rb]; end
            if (wv) mm[c][wa] = wd;
            mp[c] = p;
        end
    endtask

    task automatic idle();
        write = 0; lock = 0; ren_a = 0; ren_b = 0;
        waddr = 0; lock_addr = 0; raddr_a = 0; raddr_b = 0; wdata = 0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        write = 1; waddr = 3; wdata = 16'hFFFF; lock = 1; lock_addr = 1;
        ren_a = 1; raddr_a = 3; ren_b = 1; raddr_b = 1;
        #1;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (ara[c] !== 0 || arb[c] !== 0 || aba[c] !== 0 || abb[c] !== 0) begin
                    failures++;
                    $display("FAIL reset cfg%0d cyc%0d: rda=%h rdb=%h ba=%b bb=%b, want all 0",
                             c, k, ara[c], arb[c], aba[c], abb[c]);
                end
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        model_reset();
        idle();
    endtask

    task automatic test_basic();
        write = 1; waddr = 3; wdata = 16'h06;
        tick();
        idle(); ren_a = 1; raddr_a = 3;
        tick();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (ara[c] !== 16'h06 || aba[c] !== 1'b0) begin
                failures++;
                $display("FAIL basic_rd cfg%0d: rda=%h ba=%b, want 06/0", c, ara[c], aba[c]);
            end
        end
        idle();
    endtask

    task automatic test_bypass();
        logic [15:0] exp_b[3];
        exp_b = '{16'hA5, 16'h11, 16'hA5};
        write = 1; waddr = 2; wdata = 16'h11;
        tick();
        idle(); write = 1; waddr = 2; wdata = 16'hA5; ren_b = 1; raddr_b = 2;
        tick();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (arb[c] !== exp_b[c]) begin
                failures++;
                $display("FAIL bypass_same_edge cfg%0d: rdb=%h want %h", c, arb[c], exp_b[c]);
            end
        end
        idle(); ren_b = 1; raddr_b = 2;
        tick();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (arb[c] !== 16'hA5) begin
                failures++;
                $display("FAIL bypass_after cfg%0d: rdb=%h want a5", c, arb[c]);
            end
        end
        idle();
    endtask

    task automatic test_scoreboard();
        logic [15:0] exp_b[3], exp_a[3];
        exp_b = '{16'h3C, 16'h00, 16'h3C};
        exp_a = '{16'h55, 16'h3C, 16'h55};
        lock = 1; lock_addr = 1;
        tick();
        idle(); ren_a = 1; raddr_a = 1;
        tick();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (aba[c] !== 1'b1) begin
                failures++;
                $display("FAIL sb_locked cfg%0d: ba=%b want 1", c, aba[c]);
            end
        end
        idle(); write = 1; waddr = 1; wdata = 16'h3C; ren_b = 1; raddr_b = 1;
        tick();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (abb[c] !== 1'b0 || arb[c] !== exp_b[c]) begin
                failures++;
                $display("FAIL sb_writeback cfg%0d: rdb=%h bb=%b want %h/0", c, arb[c], abb[c], exp_b[c]);
            end
        end
        idle(); write = 1; waddr = 1; wdata = 16'h55; lock = 1; lock_addr = 1; ren_a = 1; raddr_a = 1;
        tick();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (aba[c] !== 1'b1 || ara[c] !== exp_a[c]) begin
                failures++;
                $display("FAIL sb_lock_wins cfg%0d: rda=%h ba=%b want %h/1", c, ara[c], aba[c], exp_a[c]);
            end
        end
        idle(); ren_a = 1; raddr_a = 1;
        tick();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (aba[c] !== 1'b1 || ara[c] !== 16'h55) begin
                failures++;
                $display("FAIL sb_still_pending cfg%0d: rda=%h ba=%b want 55/1", c, ara[c], aba[c]);
            end
        end
        idle();
    endtask

    task automatic test_zero_reg();
        logic [15:0] exp_d[3];
        logic        exp_bz[3];
        exp_d  = '{16'hFF, 16'h00, 16'hFF};
        exp_bz = '{1'b1, 1'b0, 1'b1};
        write = 1; waddr = 0; wdata = 16'hFF;
        tick();
        idle(); lock = 1; lock_addr = 0;
        tick();
        idle(); ren_a = 1; raddr_a = 0; ren_b = 1; raddr_b = 0;
        tick();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (ara[c] !== exp_d[c] || arb[c] !== exp_d[c] || aba[c] !== exp_bz[c] || abb[c] !== exp_bz[c]) begin
                failures++;
                $display("FAIL zero_reg cfg%0d: rda=%h rdb=%h ba=%b bb=%b want %h/%b",
                         c, ara[c], arb[c], aba[c], abb[c], exp_d[c], exp_bz[c]);
            end
        end
        idle();
    endtask

    task automatic test_hold_async_reset();
        ren_a = 1; raddr_a = 3;
        tick();
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (ara[c] !== 16'h06) begin
                    failures++;
                    $display("FAIL hold cfg%0d cyc%0d: rda=%h want 06", c, k, ara[c]);
                end
            end
            idle(); write = 1; waddr = 3; wdata = 16'h77;
            if (k < 3) tick();
        end
        idle();
        #2 rst = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (ara[c] !== 0 || arb[c] !== 0 || aba[c] !== 0 || abb[c] !== 0) begin
                failures++;
                $display("FAIL async_reset cfg%0d: rda=%h rdb=%h ba=%b bb=%b want 0",
                         c, ara[c], arb[c], aba[c], abb[c]);
            end
        end
        #1 rst = 1'b1;
        model_reset();
        ren_a = 1; raddr_a = 3; ren_b = 1; raddr_b = 1;
        tick();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (ara[c] !== 0 || arb[c] !== 0 || abb[c] !== 0) begin
                failures++;
                $display("FAIL reset_cleared cfg%0d: rda=%h rdb=%h bb=%b want 0", c, ara[c], arb[c], abb[c]);
            end
        end
        idle();
    endtask

    task automatic test_wide();
        write = 1; waddr = 7; wdata = 16'hBEEF;
        tick();
        waddr = 0; wdata = 16'h1234;
        tick();
        idle(); ren_a = 1; raddr_a = 7; ren_b = 1; raddr_b = 0;
        tick();
        checks++;
        if (rda2 !== 16'hBEEF || rdb2 !== 16'h1234) begin
            failures++;
            $display("FAIL wide cfg2: rda=%h rdb=%h want beef/1234", rda2, rdb2);
        end
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (ara[c] !== erda[c] || arb[c] !== erdb[c]) begin
                failures++;
                $display("FAIL wide_alias cfg%0d: rda=%h rdb=%h want %h/%h", c, ara[c], arb[c], erda[c], erdb[c]);
            end
        end
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            write = ($urandom_range(0, 1) == 1);
            lock = ($urandom_range(0, 3) == 0);
            ren_a = ($urandom_range(0, 3) != 0);
            ren_b = ($urandom_range(0, 3) != 0);
            waddr = 3'($urandom_range(0, 7));
            lock_addr = 3'($urandom_range(0, 7));
            raddr_a = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
            raddr_b = ($urandom_range(0, 3) == 0) ? raddr_a : 3'($urandom_range(0, 7));
            wdata = 16'($urandom);
            tick();
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (ara[c] !== erda[c] || aba[c] !== eba[c]) begin
                    failures++;
                    $display("FAIL rand_a cfg%0d n%0d: rda=%h ba=%b want %h/%b", c, n, ara[c], aba[c], erda[c], eba[c]);
                end
                checks++;
                if (arb[c] !== erdb[c] || abb[c] !== ebb[c]) begin
                    failures++;
                    $display("FAIL rand_b cfg%0d n%0d: rdb=%h bb=%b want %h/%b", c, n, arb[c], abb[c], erdb[c], ebb[c]);
                end
            end
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_bypass();
        test_scoreboard();
        test_zero_reg();
        test_hold_async_reset();
        test_wide();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
Parametrised register file for the processor datapath, generalising the single-port 4x8 register block. It has:
- one synchronous write port;
- two independently enabled read ports, each with registered outputs;
- optional write-to-read bypass;
- a per-register pending (scoreboard) bit, so the issue logic can detect a read of a register whose producer has not yet written back.

Sits between decode (read and lock requests) and writeback (writes).

Parameters:
WIDTH, 8, data width of each register in bits
ADDR_W, 2, address width; DEPTH = 2**ADDR_W registers
ZERO_REG, 0, 1 = register 0 reads as zero, ignores writes and can never be pending
BYPASS, 1, 1 = a read at the same edge as a write to the same address returns the new data

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-low
write  input  1  write enable
waddr  input  ADDR_W  write address
wdata  input  WIDTH  write data
lock  input  1  mark register lock_addr pending (producer issued)
lock_addr  input  ADDR_W  register to mark pending
ren_a  input  1  read enable, port A
raddr_a  input  ADDR_W  read address, port A
rdata_a  output  WIDTH  registered read data, port A
busy_a  output  1  registered pending status of the register read on port A
ren_b  input  1  read enable, port B
raddr_b  input  ADDR_W  read address, port B
rdata_b  output  WIDTH  registered read data, port B
busy_b  output  1  registered pending status of the register read on port B

Behaviour:
- Reset (rst=0, asynchronous, independent of clk):
  - all registers, all pending bits, rdata_a/b and busy_a/b go to 0;
  - state is held at 0 while rst=0;
  - a reset asserted mid-operation discards any in-flight write, lock or read on that edge.
- Write, at a rising edge with write=1:
  - mem[waddr] <= wdata and pending[waddr] <= 0;
  - if ZERO_REG=1 and waddr=0, the write is a complete no-op.
- Lock, at a rising edge with lock=1:
  - pending[lock_addr] <= 1;
  - if ZERO_REG=1 and lock_addr=0, the lock is ignored.
- Write and lock to the same address at the same edge:
  - the data is written;
  - pending ends at 1 (the lock wins, because a new producer was issued).
- Read, per port, independently:
  - At a rising edge with ren=1:
    - rdata <= source value;
    - busy <= next-state pending bit of raddr (i.e. after this edge's write/lock updates).
  - Latency is 1 cycle: data is visible the cycle after ren is sampled.
  - With ren=0, rdata and busy hold their previous values.
- Source value for a read:
  - ZERO_REG=1 and raddr=0: 0.
  - BYPASS=1, write=1 and waddr=raddr (address not suppressed): wdata.
  - Otherwise, including BYPASS=0: current mem[raddr], i.e. the pre-write value.
- Both ports may read the same address at the same edge; each gets an identical result.
- Out-of-range addresses cannot occur, since DEPTH = 2**ADDR_W.
- Width handling:
  - wdata is stored unmodified;
  - there is no arithmetic, and no truncation or extension inside the block.

Test Plan:
1. Reset and basic write/read:
   - Stimulus: hold rst=0 for 2 cycles, release; write 8'h06 to reg 3; next cycle ren_a=1, raddr_a=3.
   - Required: rdata_a=8'h06 and busy_a=0 one cycle later; all outputs are 0 during reset.
2. Bypass (BYPASS=1 and BYPASS=0):
   - Stimulus: reg 2 holds 8'h11; at the same edge write=1, waddr=2, wdata=8'hA5 and ren_b=1, raddr_b=2.
   - Required: rdata_b=8'hA5 with BYPASS=1; rdata_b=8'h11 with BYPASS=0; a following read returns 8'hA5 in both cases.
3. Scoreboard:
   - Stimulus: lock reg 1; read reg 1 on port A; then write 8'h3C to reg 1 while also reading reg 1 on port B.
   - Required: busy_a=1 after the first read; busy_b=0 and rdata_b=8'h3C after the write edge. Separately, with lock and write to reg 1 at the same edge, pending stays 1.
4. ZERO_REG=1:
   - Stimulus: write 8'hFF to reg 0; lock reg 0; read reg 0 on both ports.
   - Required: rdata_a=rdata_b=0 and busy_a=busy_b=0.
5. Hold and async reset:
   - Stimulus: read reg 3 (8'h06), then drop ren_a for 3 cycles while writing 8'h77 to reg 3; then pulse rst low between clock edges.
   - Required: rdata_a stays 8'h06 while ren_a=0; on the rst pulse, rdata_a and all registers clear to 0 immediately, without waiting for a clock edge.
6. Parametrised build:
   - Configuration: WIDTH=16, ADDR_W=3.
   - Stimulus: write 16'hBEEF to reg 7 and 16'h1234 to reg 0 (ZERO_REG=0), then read both on ports A and B at the same edge.
   - Required: 16'hBEEF on port A and 16'h1234 on port B, one cycle after the read edge.
